mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: controller states,
// requester indices and the in-flight tracking entry.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StRun,
        StDraining,
        StDrained
    } arb_state_e;

    localparam logic PortFetch = 1'b0;
    localparam logic PortData  = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } inflight_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between a fetch and a
// data requester, with a drain handshake and per-port grant counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    input  logic [3:0]  req_we0,
    input  logic [3:0]  req_we1,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        drain,
    output logic        drained,
    output logic [31:0] grant_cnt0,
    output logic [31:0] grant_cnt1
);

    localparam int Lat = int'(MEM_LATENCY);

    arb_state_e  state_q, state_d;
    logic        rr_q;
    logic [31:0] cnt0_q, cnt1_q;
    inflight_t   pipe_q [Lat];

    logic grant;
    logic gnt_port;
    logic in_flight;

    // Grants stop in the very cycle drain is raised, before the state leaves RUN.
    always_comb begin
        grant    = 1'b0;
        gnt_port = PortFetch;
        if (!rst && state_q == StRun && !drain) begin
            if (req_valid == 2'b11) begin
                grant    = 1'b1;
                gnt_port = rr_q;
            end else if (req_valid[0]) begin
                grant    = 1'b1;
                gnt_port = PortFetch;
            end else if (req_valid[1]) begin
                grant    = 1'b1;
                gnt_port = PortData;
            end
        end
    end

    always_comb begin
        req_ready = 2'b00;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_we    = 4'h0;
        if (grant) begin
            if (gnt_port == PortData) begin
                req_ready = 2'b10;
                mem_addr  = req_addr1;
                mem_wdata = req_wdata1;
                mem_we    = req_we1;
            end else begin
                req_ready = 2'b01;
                mem_addr  = req_addr0;
                mem_wdata = req_wdata0;
                mem_we    = req_we0;
            end
        end
    end

    always_comb begin
        resp_valid = 2'b00;
        resp_data  = 32'h0;
        if (!rst && pipe_q[Lat-1].valid) begin
            resp_valid = pipe_q[Lat-1].port ? 2'b10 : 2'b01;
            resp_data  = mem_rdata;
        end
    end

    // The last stage is answered this cycle, so only earlier stages keep the port busy.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < Lat - 1; i++) begin
            in_flight = in_flight | pipe_q[i].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:      if (drain) state_d = StDraining;
            StDraining: begin
                if (!drain) begin
                    state_d = StRun;
                end else if (!in_flight) begin
                    state_d = StDrained;
                end
            end
            StDrained:  if (!drain) state_d = StRun;
            default:    state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            rr_q    <= PortFetch;
            cnt0_q  <= 32'h0;
            cnt1_q  <= 32'h0;
            for (int i = 0; i < Lat; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pipe_q[0] <= '{valid: grant, port: gnt_port};
            for (int i = 1; i < Lat; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (grant) begin
                rr_q <= ~gnt_port;
                if (gnt_port == PortData) begin
                    cnt1_q <= cnt1_q + 32'd1;
                end else begin
                    cnt0_q <= cnt0_q + 32'd1;
                end
            end
        end
    end

    assign drained    = !rst && (state_q == StDrained);
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a request-level model predicts
// grants and queues expected responses; a separate monitor matches them.
module tb_mem_port_arbiter;

    localparam int Lat = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [3:0]  req_we0, req_we1;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic        drain, drained;
    logic [31:0] grant_cnt0, grant_cnt1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
        logic        is_store;
    } exp_t;
    exp_t sb[$];

    // Model: 0 = run, 1 = draining, 2 = drained
    int          m_mode = 0;
    logic        m_rr = 1'b0;
    logic [31:0] m_cnt0 = 32'h0;
    logic [31:0] m_cnt1 = 32'h0;

    mem_port_arbiter #(.MEM_LATENCY(Lat)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_we0    (req_we0),
        .req_we1    (req_we1),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .drain      (drain),
        .drained    (drained),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rdata_of(int c);
        logic [31:0] cc;
        cc = c;
        return (cc * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    assign mem_rdata = rdata_of(cyc);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(string name, string what);
        checks++;
        errors++;
        $display("FAIL %s cycle %0d: %s", name, cyc, what);
    endtask

    // Reference model, evaluated mid-cycle once inputs are stable.
    always @(negedge clk) begin
        logic        g, p, pending;
        logic [31:0] ea, ew;
        logic [3:0]  ewe;
        if (rst) begin
            chk("rst_ready", {30'h0, req_ready}, 32'h0);
            chk("rst_resp_valid", {30'h0, resp_valid}, 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
            chk("rst_drained", {31'h0, drained}, 32'h0);
            sb.delete();
            m_mode = 0;
            m_rr   = 1'b0;
            m_cnt0 = 32'h0;
            m_cnt1 = 32'h0;
        end else begin
            g = 1'b0;
            p = 1'b0;
            if (m_mode == 0 && !drain && req_valid != 2'b00) begin
                g = 1'b1;
                p = (req_valid == 2'b11) ? m_rr : req_valid[1];
            end
            ea  = !g ? 32'h0 : (p ? req_addr1 : req_addr0);
            ew  = !g ? 32'h0 : (p ? req_wdata1 : req_wdata0);
            ewe = !g ? 4'h0 : (p ? req_we1 : req_we0);
            chk("req_ready", {30'h0, req_ready}, !g ? 32'h0 : (p ? 32'h2 : 32'h1));
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ew);
            chk("mem_we", {28'h0, mem_we}, {28'h0, ewe});
            chk("drained", {31'h0, drained}, (m_mode == 2) ? 32'h1 : 32'h0);
            chk("grant_cnt0", grant_cnt0, m_cnt0);
            chk("grant_cnt1", grant_cnt1, m_cnt1);
            if (g) begin
                sb.push_back('{due: cyc + Lat, port: p, data: rdata_of(cyc + Lat),
                               is_store: (ewe != 4'h0)});
                if (p) m_cnt1 = m_cnt1 + 32'd1;
                else   m_cnt0 = m_cnt0 + 32'd1;
                m_rr = ~p;
            end
            pending = 1'b0;
            foreach (sb[i]) if (sb[i].due > cyc) pending = 1'b1;
            case (m_mode)
                0: if (drain) m_mode = 1;
                1: if (!drain) m_mode = 0; else if (!pending) m_mode = 2;
                default: if (!drain) m_mode = 0;
            endcase
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                flag("resp_missing", "expected response never arrived");
                void'(sb.pop_front());
            end
            if (resp_valid != 2'b00) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    flag("resp_unexpected", $sformatf("resp_valid=%b with none due", resp_valid));
                end else begin
                    chk("resp_port", {30'h0, resp_valid}, sb[0].port ? 32'h2 : 32'h1);
                    if (!sb[0].is_store) chk("resp_data", resp_data, sb[0].data);
                    void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && sb[0].due == cyc) begin
                flag("resp_missing", "resp_valid low in due cycle");
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        req_valid  = 2'b00;
        req_addr0  = 32'h0;
        req_addr1  = 32'h0;
        req_wdata0 = 32'h0;
        req_wdata1 = 32'h0;
        req_we0    = 4'h0;
        req_we1    = 4'h0;
    endtask

    initial begin
        rst   = 1'b1;
        drain = 1'b0;
        idle_inputs();
        step(3);
        rst = 1'b0;

        // Single fetch
        req_valid = 2'b01;
        req_addr0 = 32'h10;
        step(1);
        idle_inputs();
        step(4);

        // Contention straight after reset: 0,1,0,1
        rst = 1'b1;
        step(1);
        rst       = 1'b0;
        req_valid = 2'b11;
        req_addr0 = 32'h100;
        req_addr1 = 32'h200;
        step(4);
        idle_inputs();
        chk("contention_cnt0", grant_cnt0, 32'd2);
        chk("contention_cnt1", grant_cnt1, 32'd2);
        step(4);

        // Store on the data port
        req_valid  = 2'b10;
        req_addr1  = 32'h20;
        req_wdata1 = 32'hDEAD_BEEF;
        req_we1    = 4'b0011;
        step(1);
        idle_inputs();
        step(4);

        // Drain with a grant in flight, requests held pending throughout
        req_valid = 2'b01;
        req_addr0 = 32'h40;
        step(1);
        drain     = 1'b1;
        req_valid = 2'b11;
        step(6);
        drain = 1'b0;
        step(3);
        idle_inputs();
        step(4);

        // Drain with nothing in flight
        drain = 1'b1;
        step(4);
        drain = 1'b0;
        step(2);

        // Reset mid-flight
        req_valid = 2'b01;
        req_addr0 = 32'h80;
        step(1);
        idle_inputs();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);

        // Counter wrap
        force dut.cnt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt0_q;
        m_cnt0 = 32'hFFFF_FFFF;
        step(1);
        req_valid = 2'b01;
        step(1);
        idle_inputs();
        step(2);
        chk("wrap_cnt0", grant_cnt0, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid  = 2'($urandom);
            req_addr0  = $urandom;
            req_addr1  = $urandom;
            req_wdata0 = $urandom;
            req_wdata1 = $urandom;
            req_we0    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            req_we1    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 99) < 4) drain = ~drain;
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst   = 1'b0;
        drain = 1'b0;
        idle_inputs();
        step(Lat + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
